// File: rtl/fir_axil_ctrl.sv
// rtl/fir_axil_ctrl.sv - AXI-Lite register slave and job controller for the FIR datapath
//
// Terminates the AXI-Lite write/read channels from the bridge, decodes the FIR
// register map (ap_ctrl 0x00, data_length 0x10, taps 0x40+4*i), drives the tap
// coefficient SRAM port, and tracks output-stream handshakes to produce
// ap_start/ap_done/ap_idle.
//
// Optional build macro: FIR_TLAST_CHECK_EN adds the sticky ap_ctrl bit3 error
// flag that records sm_tlast disagreeing with the expected last beat.
//
// Ports:
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   awvalid/awready/awaddr        write address channel
//   wvalid/wready/wdata           write data channel (ack together with awready)
//   arvalid/arready/araddr        read address channel
//   rvalid/rready/rdata           read data channel
//   tap_en/tap_we/tap_addr/tap_di tap SRAM port (byte address 4*i)
//   tap_do                        tap SRAM read data, one-cycle latency
//   ss_tvalid/ss_tready           input-stream handshake (observed only)
//   sm_tvalid/sm_tready/sm_tlast  output-stream handshake, counts job progress
//   ap_start_o                    one-cycle start pulse to the datapath
//   data_length_o                 current data_length register
//   busy_o                        high while a job runs (ap_idle == 0)

module fir_axil_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   tap_en,
  output logic [3:0]             tap_we,
  output logic [pADDR_WIDTH-1:0] tap_addr,
  output logic [pDATA_WIDTH-1:0] tap_di,
  input  logic [pDATA_WIDTH-1:0] tap_do,
  input  logic                   ss_tvalid,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic                   sm_tready,
  input  logic                   sm_tlast,
  output logic                   ap_start_o,
  output logic [pDATA_WIDTH-1:0] data_length_o,
  output logic                   busy_o
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(64);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(64 + 4 * (pTAP_NUM - 1));

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  // Write-side latches (captured when the request is accepted)
  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic                   w_tap_wr;

  // Read-side latches
  logic [pADDR_WIDTH-1:0] r_addr;
  logic                   r_tap_rd;
  logic                   r_first;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] rd_mux;

  // Job state
  logic                   ap_idle;
  logic                   ap_done;
  logic                   ap_err;
  logic                   ap_start_q;
  logic [pDATA_WIDTH-1:0] data_length;
  logic [pDATA_WIDTH-1:0] sm_cnt;

  logic w_req, w_tap_req, r_stall, r_tap_ok;
  logic start_req, len_wr, ctrl_rd;
  logic sm_hs, sm_last;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= ADDR_TAP0) && (a <= ADDR_TAPN) && (a[1:0] == 2'b00);
  endfunction

  assign w_req     = (w_state == W_IDLE) && awvalid && wvalid;
  // Only a tap write that really reaches the SRAM contends with a tap read.
  assign w_tap_req = w_req && is_tap(awaddr) && ap_idle;
  // The read's SRAM cycle (R_ADDR) would land on the write's SRAM cycle
  // (W_RESP), so the read yields and retries from R_IDLE next cycle.
  assign r_stall   = w_tap_req && is_tap(araddr);
  assign r_tap_ok  = is_tap(r_addr) && ap_idle;

  assign start_req = w_req && (awaddr == ADDR_CTRL) && wdata[0] && ap_idle;
  assign len_wr    = w_req && (awaddr == ADDR_LEN) && ap_idle;
  assign ctrl_rd   = (r_state == R_ADDR) && (r_addr == ADDR_CTRL);

  assign sm_hs     = sm_tvalid && sm_tready && !ap_idle;
  assign sm_last   = (sm_cnt == data_length - pDATA_WIDTH'(1));

  // ---------------- write FSM ----------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) w_state <= W_IDLE;
    else             w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    case (w_state)
      W_IDLE: if (w_req) w_state_nxt = W_RESP;
      W_RESP: begin
        awready     = 1'b1;
        wready      = 1'b1;
        w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= R_IDLE;
    else             r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: if (arvalid && !r_stall) r_state_nxt = R_ADDR;
      R_ADDR: begin
        arready     = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // ---------------- tap SRAM port ----------------
  always_comb begin
    tap_en   = 1'b0;
    tap_we   = 4'h0;
    tap_addr = '0;
    tap_di   = '0;
    if ((w_state == W_RESP) && w_tap_wr) begin
      tap_en   = 1'b1;
      tap_we   = 4'hF;
      tap_addr = w_addr - ADDR_TAP0;
      tap_di   = w_data;
    end else if ((r_state == R_ADDR) && r_tap_ok) begin
      tap_en   = 1'b1;
      tap_addr = r_addr - ADDR_TAP0;
    end
  end

  // ---------------- read data ----------------
  always_comb begin
    rd_mux = '0;
    if (r_addr == ADDR_CTRL)
      rd_mux = pDATA_WIDTH'({ap_err, ap_idle, ap_done, 1'b0});
    else if (r_addr == ADDR_LEN)
      rd_mux = data_length;
    else if (is_tap(r_addr))
      rd_mux = r_tap_ok ? '0 : '1;
  end

  // SRAM data arrives in the first R_DATA cycle; it is presented directly
  // then and held in rdata_q for any following wait cycles.
  assign rdata = ((r_state == R_DATA) && r_first && r_tap_rd) ? tap_do : rdata_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      w_addr   <= '0;
      w_data   <= '0;
      w_tap_wr <= 1'b0;
      r_addr   <= '0;
      r_tap_rd <= 1'b0;
      r_first  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (w_req) begin
        w_addr   <= awaddr;
        w_data   <= wdata;
        w_tap_wr <= w_tap_req;
      end
      if ((r_state == R_IDLE) && (r_state_nxt == R_ADDR))
        r_addr <= araddr;
      r_first <= (r_state == R_ADDR);
      if (r_state == R_ADDR) begin
        r_tap_rd <= r_tap_ok;
        rdata_q  <= rd_mux;
      end else if ((r_state == R_DATA) && r_first && r_tap_rd) begin
        rdata_q  <= tap_do;
      end
    end
  end

  // ---------------- job control ----------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_idle     <= 1'b1;
      ap_done     <= 1'b0;
      ap_start_q  <= 1'b0;
      data_length <= '0;
      sm_cnt      <= '0;
    end else begin
      ap_start_q <= start_req;
      if (len_wr) data_length <= wdata;
      if (start_req) begin
        ap_idle <= 1'b0;
        ap_done <= 1'b0;
        sm_cnt  <= '0;
      end else if (ap_start_q && (data_length == '0)) begin
        // Zero-length job finishes immediately after the start pulse.
        ap_idle <= 1'b1;
        ap_done <= 1'b1;
      end else begin
        if (sm_hs) begin
          sm_cnt <= sm_cnt + pDATA_WIDTH'(1);
          if (sm_last) begin
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
          end
        end
        // Read-to-clear loses against a same-cycle completion.
        if (ctrl_rd && !(sm_hs && sm_last)) ap_done <= 1'b0;
      end
    end
  end

`ifdef FIR_TLAST_CHECK_EN
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)                          ap_err <= 1'b0;
    else if (start_req)                       ap_err <= 1'b0;
    else if (sm_hs && (sm_tlast != sm_last))  ap_err <= 1'b1;
  end

  logic unused_ss;
  assign unused_ss = ss_tvalid ^ ss_tready;
`else
  assign ap_err = 1'b0;

  logic unused_ss;
  assign unused_ss = ss_tvalid ^ ss_tready ^ sm_tlast;
`endif

  assign ap_start_o    = ap_start_q;
  assign data_length_o = data_length;
  assign busy_o        = ~ap_idle;

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// tb/tb_fir_axil_ctrl.sv - self-checking bench for fir_axil_ctrl
module tb_fir_axil_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, arready, rvalid;
  logic [DW-1:0] rdata;
  logic          tap_en;
  logic [3:0]    tap_we;
  logic [AW-1:0] tap_addr;
  logic [DW-1:0] tap_di;
  logic [DW-1:0] tap_do = '0;
  logic          ss_tvalid = 0, ss_tready = 0;
  logic          sm_tvalid = 0, sm_tready = 0, sm_tlast = 0;
  logic          ap_start_o, busy_o;
  logic [DW-1:0] data_length_o;

  always #5 axis_clk = ~axis_clk;

  fir_axil_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAP_NUM(NT)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_en(tap_en), .tap_we(tap_we), .tap_addr(tap_addr), .tap_di(tap_di), .tap_do(tap_do),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .ap_start_o(ap_start_o), .data_length_o(data_length_o), .busy_o(busy_o)
  );

  // Tap coefficient SRAM: one-cycle read latency
  logic [DW-1:0] sram [NT];
  initial for (int i = 0; i < NT; i++) sram[i] = '0;
  always @(posedge axis_clk) begin
    int idx;
    idx = int'(tap_addr >> 2);
    if (tap_en && idx < NT) begin
      if (tap_we == 4'hF) sram[idx] <= tap_di;
      tap_do <= sram[idx];
    end
  end

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int we_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference model of the register map / job
  logic [DW-1:0] m_taps [NT];
  logic [DW-1:0] m_len = 0;
  bit m_done = 0, m_idle = 1, m_err = 0;
  int m_beats = 0;

  function automatic int tap_index(input logic [AW-1:0] a);
    if (a >= 64 && a <= 64 + 4 * (NT - 1) && a % 4 == 0) return (int'(a) - 64) / 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_len = 0; m_done = 0; m_idle = 1; m_err = 0; m_beats = 0;
  endtask

  task automatic model_rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    int ti;
    bit errv;
`ifdef FIR_TLAST_CHECK_EN
    errv = m_err;
`else
    errv = 1'b0;
`endif
    ti = tap_index(a);
    if (a == 0) begin
      v = {28'd0, errv, m_idle, m_done, 1'b0};
      m_done = 0;
    end else if (a == 16) v = m_len;
    else if (ti >= 0) v = m_idle ? m_taps[ti] : 32'hFFFF_FFFF;
    else v = 0;
  endtask

  task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit pulse, output bit we);
    int ti;
    ti = tap_index(a);
    pulse = 0; we = 0;
    if (a == 0) begin
      if (d[0] && m_idle) begin
        pulse = 1; m_idle = 0; m_done = 0; m_beats = 0; m_err = 0;
        if (m_len == 0) begin m_done = 1; m_idle = 1; end
      end
    end else if (a == 16) begin
      if (m_idle) m_len = d;
    end else if (ti >= 0 && m_idle) begin
      m_taps[ti] = d; we = 1;
    end
  endtask

  task automatic model_beat(input bit last);
    if (!m_idle) begin
      if (last != (m_beats == int'(m_len) - 1)) m_err = 1;
      m_beats++;
      if (m_beats == int'(m_len)) begin m_done = 1; m_idle = 1; end
    end
  endtask

  // Monitor: counts pulses / SRAM writes, scores every read response
  always @(negedge axis_clk) begin
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    if (ap_start_o) pulse_cnt++;
    if (tap_we != 4'h0) we_cnt++;
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected act=%h exp=none", rdata);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rdata@%h", a), rdata, e);
      end
    end
  end

  task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int p0, w0, n;
    bit ep, ew;
    p0 = pulse_cnt; w0 = we_cnt;
    model_wr(a, d, ep, ew);
    @(posedge axis_clk); #1;
    awvalid = 1; wvalid = 1; awaddr = a; wdata = d;
    n = 0;
    @(negedge axis_clk);
    while (!wready && n < 20) begin @(negedge axis_clk); n++; end
    check("wr_latency", n, 1);
    check("awready_with_wready", awready, wready);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge axis_clk);
    check($sformatf("start_pulses@%h", a), pulse_cnt - p0, ep);
    check($sformatf("tap_we_cycles@%h", a), we_cnt - w0, ew);
  endtask

  task automatic axil_read(input logic [AW-1:0] a, input int lat);
    logic [DW-1:0] e;
    int n;
    bit saw_ar;
    model_rd(a, e);
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(posedge axis_clk); #1;
    arvalid = 1; araddr = a; rready = 1'($urandom_range(0, 1));
    n = 0; saw_ar = 0;
    @(negedge axis_clk);
    while (!rvalid && n < 20) begin
      if (arready) saw_ar = 1;
      @(negedge axis_clk);
      n++;
    end
    arvalid = 0;
    check("rd_latency", n, lat);
    check("arready_seen", saw_ar, 1);
    if (!rready) begin
      repeat (1 + $urandom_range(0, 2)) @(posedge axis_clk);
      #1 rready = 1;
    end
    @(posedge axis_clk); #1;
    rready = 0;
  endtask

  task automatic sm_beats(input int n, input int tlast_at);
    int k, it;
    k = 0; it = 0;
    while (k < n && it < 4000) begin
      @(posedge axis_clk); #1;
      sm_tvalid = 1'($urandom_range(0, 1));
      sm_tready = ($urandom_range(0, 3) != 0);
      sm_tlast  = (k == tlast_at);
      ss_tvalid = 1'($urandom_range(0, 1));
      ss_tready = 1'($urandom_range(0, 1));
      @(negedge axis_clk);
      if (sm_tvalid && sm_tready) begin model_beat(sm_tlast); k++; end
      it++;
    end
    check("beats_done", k, n);
    @(posedge axis_clk); #1;
    sm_tvalid = 0; sm_tready = 0; sm_tlast = 0; ss_tvalid = 0; ss_tready = 0;
  endtask

  task automatic check_status(input string tag);
    @(negedge axis_clk);
    check({"busy_o ", tag}, busy_o, !m_idle);
    check({"data_length_o ", tag}, data_length_o, m_len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] e;
    for (int i = 0; i < NT; i++) m_taps[i] = '0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    check("reset_handshakes", {awready, wready, arready, rvalid, tap_en, tap_we, ap_start_o, busy_o}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_data_length", data_length_o, 0);
    @(posedge axis_clk); #1 axis_rst_n = 1;
    axil_read(0, 2);

    // Taps: sequential values, then random values read back in random order
    for (int i = 0; i < NT; i++) axil_write(AW'(64 + 4 * i), DW'(i));
    for (int i = 0; i < NT; i++) axil_read(AW'(64 + 4 * i), 2);
    for (int i = 0; i < NT; i++) axil_write(AW'(64 + 4 * i), $urandom);
    for (int i = 0; i < 2 * NT; i++) axil_read(AW'(64 + 4 * $urandom_range(0, NT - 1)), 2);

    // Simultaneous tap write and tap read: read waits one cycle
    fork
      axil_write(AW'(72), $urandom);
      axil_read(AW'(80), 3);
    join

    // Unmapped addresses
    axil_write(AW'(32), $urandom);
    axil_read(AW'(32), 2);
    axil_write(AW'(64 + 4 * NT), $urandom);
    axil_read(AW'(64 + 4 * NT), 2);
    axil_read(AW'(8), 2);

    // Length-64 job with busy-time accesses
    axil_write(16, 64);
    axil_read(16, 2);
    axil_write(0, 1);
    check_status("after_start");
    axil_write(AW'(68), 32'h55);
    axil_read(AW'(68), 2);
    axil_write(16, 7);
    axil_write(0, 1);
    axil_read(0, 2);
    check_status("busy");
    sm_beats(64, 63);
    check_status("done64");
    axil_read(0, 2);
    axil_read(0, 2);
    axil_read(AW'(68), 2);
    axil_read(16, 2);

    // Zero-length job: done/idle the cycle after the start pulse
    axil_write(16, 0);
    axil_write(0, 1);
    @(negedge axis_clk);
    check("len0_busy_after_pulse", busy_o, 0);
    axil_read(0, 2);

    // Read of ap_ctrl coinciding with the final handshake
    axil_write(16, 3);
    axil_write(0, 1);
    sm_beats(2, 2);
    model_rd(0, e);
    exp_q.push_back(e);
    addr_q.push_back(0);
    @(posedge axis_clk); #1;
    arvalid = 1; araddr = 0; rready = 1;
    @(posedge axis_clk); #1;
    sm_tvalid = 1; sm_tready = 1; sm_tlast = 1;
    @(negedge axis_clk);
    check("arready_same_cycle", arready, 1);
    model_beat(1);
    @(posedge axis_clk); #1;
    sm_tvalid = 0; sm_tready = 0; sm_tlast = 0; arvalid = 0;
    @(negedge axis_clk);
    @(posedge axis_clk); #1 rready = 0;
    axil_read(0, 2);

    // tlast on the wrong beat
    axil_write(16, 4);
    axil_write(0, 1);
    sm_beats(4, 2);
    axil_read(0, 2);
    axil_write(0, 1);
    axil_read(0, 2);
    sm_beats(4, 3);
    axil_read(0, 2);

    // Reset in the middle of a read during a job
    axil_write(16, 5);
    axil_write(0, 1);
    @(posedge axis_clk); #1;
    arvalid = 1; araddr = 16; rready = 0;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    check("rvalid_before_reset", rvalid, 1);
    #2 axis_rst_n = 0;
    #1;
    check("rvalid_in_reset", rvalid, 0);
    check("busy_in_reset", busy_o, 0);
    arvalid = 0;
    model_reset();
    @(posedge axis_clk); #1 axis_rst_n = 1;
    axil_read(16, 2);
    axil_read(0, 2);
    axil_read(AW'(64), 2);

    repeat (5) @(posedge axis_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
